nonce_search_ctrl: RTL and testbench

- Sequential controller that drives nonces into the combinational 256-bit-nonce SHA-256 hash block and consumes its 256-bit digest.
- Issues nonce_base, nonce_base+1, … one at a time, waits a fixed settle latency, then compares the digest against a 256-bit target.
- Stops on the first digest strictly below the target, or when count_limit nonces have been tried.
- Sits between the job/host interface and the hash block.

---
 rtl/nonce_search_ctrl.sv | 175 +++++++++++++++++
 tb/tb_nonce_search_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl: steps nonces through an external combinational hash
// block, waits a fixed settle time, and stops on the first digest below the
// target or when the requested number of nonces has been evaluated.
module nonce_search_ctrl #(
   parameter int unsigned HASH_LATENCY = 1,
   parameter int unsigned WAIT_W       = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [255:0] nonce_base,
   input  logic [31:0]  count_limit,
   input  logic [255:0] target,
   output logic [255:0] nonce_out,
   input  logic [255:0] hash_digest,
   output logic         busy,
   output logic         done,
   output logic         found,
   output logic [255:0] found_nonce,
   output logic [255:0] found_digest,
   output logic [31:0]  tried_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [255:0]      nonce_q, nonce_d;
   logic [255:0]      target_q, target_d;
   logic [31:0]       limit_q, limit_d;
   logic [31:0]       tried_q, tried_d;
   logic              found_q, found_d;
   logic [255:0]      found_nonce_q, found_nonce_d;
   logic [255:0]      found_digest_q, found_digest_d;

   logic wait_done;
   logic hit;
   logic last_nonce;

   assign wait_done  = (wait_cnt_q == WAIT_W'(HASH_LATENCY - 1));
   assign hit        = (hash_digest < target_q);
   assign last_nonce = ((tried_q + 32'd1) == limit_q);

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decision; abort overrides start and evaluation.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = (count_limit != '0) ? ST_WAIT : ST_DONE;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (wait_done) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (hit || last_nonce) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy = (state_q == ST_WAIT) || (state_q == ST_CHECK);
      done = (state_q == ST_DONE);
   end

   // Datapath next values: job capture, settle counting, digest evaluation.
   always_comb begin
      wait_cnt_d     = wait_cnt_q;
      nonce_d        = nonce_q;
      target_d       = target_q;
      limit_d        = limit_q;
      tried_d        = tried_q;
      found_d        = found_q;
      found_nonce_d  = found_nonce_q;
      found_digest_d = found_digest_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (abort) begin
               found_d = 1'b0;
            end else if (start) begin
               found_d = 1'b0;
               tried_d = '0;
               // A zero-length job leaves the presented nonce untouched.
               if (count_limit != '0) begin
                  nonce_d    = nonce_base;
                  target_d   = target;
                  limit_d    = count_limit;
                  wait_cnt_d = '0;
               end
            end
         end
         ST_WAIT: begin
            if (!abort) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_CHECK: begin
            if (!abort) begin
               tried_d = tried_q + 32'd1;
               if (hit) begin
                  found_d        = 1'b1;
                  found_nonce_d  = nonce_q;
                  found_digest_d = hash_digest;
               end else if (!last_nonce) begin
                  // Only the low word advances; the upper 224 bits are fixed per job.
                  nonce_d    = {nonce_q[255:32], nonce_q[31:0] + 32'd1};
                  wait_cnt_d = '0;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers with synchronous reset to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q     <= '0;
         nonce_q        <= '0;
         target_q       <= '0;
         limit_q        <= '0;
         tried_q        <= '0;
         found_q        <= 1'b0;
         found_nonce_q  <= '0;
         found_digest_q <= '0;
      end else begin
         wait_cnt_q     <= wait_cnt_d;
         nonce_q        <= nonce_d;
         target_q       <= target_d;
         limit_q        <= limit_d;
         tried_q        <= tried_d;
         found_q        <= found_d;
         found_nonce_q  <= found_nonce_d;
         found_digest_q <= found_digest_d;
      end
   end

   assign nonce_out    = nonce_q;
   assign tried_count  = tried_q;
   assign found        = found_q;
   assign found_nonce  = found_nonce_q;
   assign found_digest = found_digest_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl. A stub stands in for the hash block:
// nonce 0 returns the real SHA-256 digest used in the zero-nonce case, any
// other nonce returns nonce XOR a fixed pattern.
module tb_nonce_search_ctrl;

   localparam logic [255:0] SHA_ZERO =
      256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;
   localparam logic [255:0] UPPER_B3 = {224'hAAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA_5555, 32'h0};
   localparam logic [223:0] UPPER_W  = 224'h0123456789abcdef0123456789abcdef0123456789abcdef01234567;

   logic         clk = 1'b0;
   logic         rst, start, abort;
   logic [255:0] nonce_base, target;
   logic [31:0]  count_limit;

   logic [255:0] nonce_out, hash_digest, found_nonce, found_digest;
   logic         busy, done, found;
   logic [31:0]  tried_count;

   logic [255:0] nonce_out3, hash_digest3, found_nonce3, found_digest3;
   logic         busy3, done3, found3;
   logic [31:0]  tried_count3;

   int checks   = 0;
   int failures = 0;

   function automatic logic [255:0] fake_hash(input logic [255:0] n);
      if (n == '0) return SHA_ZERO;
      return n ^ {8{32'h5A5A_5A5A}};
   endfunction

   assign hash_digest  = fake_hash(nonce_out);
   assign hash_digest3 = fake_hash(nonce_out3);

   nonce_search_ctrl #(.HASH_LATENCY(1), .WAIT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .nonce_base(nonce_base), .count_limit(count_limit), .target(target),
      .nonce_out(nonce_out), .hash_digest(hash_digest),
      .busy(busy), .done(done), .found(found),
      .found_nonce(found_nonce), .found_digest(found_digest),
      .tried_count(tried_count)
   );

   nonce_search_ctrl #(.HASH_LATENCY(3), .WAIT_W(8)) dut3 (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .nonce_base(nonce_base), .count_limit(count_limit), .target(target),
      .nonce_out(nonce_out3), .hash_digest(hash_digest3),
      .busy(busy3), .done(done3), .found(found3),
      .found_nonce(found_nonce3), .found_digest(found_digest3),
      .tried_count(tried_count3)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic launch(input logic [255:0] b, input logic [255:0] t, input logic [31:0] l);
      nonce_base  = b;
      target      = t;
      count_limit = l;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      nonce_base = '0; target = '0; count_limit = '0;
      tick(); tick();
      check_val("rst_nonce", nonce_out, '0);
      check_val("rst_busy", {255'd0, busy}, '0);
      check_val("rst_done", {255'd0, done}, '0);
      check_val("rst_found", {255'd0, found}, '0);
      check_val("rst_tried", {224'd0, tried_count}, '0);
      rst = 1'b0;

      // Zero-nonce hit
      launch('0, '1, 32'd4);
      check_val("zh_busy_e0", {255'd0, busy}, 256'd1);
      tick(); tick();
      check_val("zh_done", {255'd0, done}, 256'd1);
      check_val("zh_found", {255'd0, found}, 256'd1);
      check_val("zh_fnonce", found_nonce, '0);
      check_val("zh_fdigest", found_digest, SHA_ZERO);
      check_val("zh_tried", {224'd0, tried_count}, 256'd1);
      check_val("zh_busy", {255'd0, busy}, '0);

      // Exhaust without hit, with ignored start pulses at E3 and E5
      launch(UPPER_B3 | 256'h10, '0, 32'd5);
      for (int e = 1; e <= 10; e++) begin
         if (e == 3 || e == 5) start = 1'b1;
         tick();
         start = 1'b0;
         if (e == 4) check_val("ex_tried_e4", {224'd0, tried_count}, 256'd2);
         if (e == 9) check_val("ex_done_e9", {255'd0, done}, '0);
      end
      check_val("ex_done", {255'd0, done}, 256'd1);
      check_val("ex_found", {255'd0, found}, '0);
      check_val("ex_tried", {224'd0, tried_count}, 256'd5);
      check_val("ex_nonce", nonce_out, UPPER_B3 | 256'h14);

      // Equal digest is a miss; one below is a hit
      launch(256'h7, fake_hash(256'h7), 32'd1);
      tick(); tick();
      check_val("eq_done", {255'd0, done}, 256'd1);
      check_val("eq_found", {255'd0, found}, '0);
      check_val("eq_tried", {224'd0, tried_count}, 256'd1);
      launch(256'h7, fake_hash(256'h7) + 256'd1, 32'd1);
      tick(); tick();
      check_val("lt_found", {255'd0, found}, 256'd1);
      check_val("lt_fnonce", found_nonce, 256'h7);
      check_val("lt_fdigest", found_digest, fake_hash(256'h7));

      // Low-word wrap
      launch({UPPER_W, 32'hFFFF_FFFF}, '0, 32'd2);
      tick(); tick();
      check_val("wr_nonce2", nonce_out, {UPPER_W, 32'h0});
      tick(); tick();
      check_val("wr_done", {255'd0, done}, 256'd1);
      check_val("wr_tried", {224'd0, tried_count}, 256'd2);

      // count_limit = 0
      launch(256'h55, '0, 32'd0);
      check_val("cz_done", {255'd0, done}, 256'd1);
      check_val("cz_found", {255'd0, found}, '0);
      check_val("cz_tried", {224'd0, tried_count}, '0);
      check_val("cz_nonce", nonce_out, {UPPER_W, 32'h0});

      // Reset during WAIT of the third nonce
      launch(256'h100, '0, 32'd10);
      repeat (4) tick();
      check_val("rm_busy", {255'd0, busy}, 256'd1);
      check_val("rm_tried_pre", {224'd0, tried_count}, 256'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rm_nonce", nonce_out, '0);
      check_val("rm_busy0", {255'd0, busy}, '0);
      check_val("rm_tried", {224'd0, tried_count}, '0);
      check_val("rm_fnonce", found_nonce, '0);
      check_val("rm_fdigest", found_digest, '0);

      // Abort during WAIT of the third nonce
      launch(256'h100, '0, 32'd10);
      repeat (4) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("ab_busy", {255'd0, busy}, '0);
      check_val("ab_done", {255'd0, done}, '0);
      check_val("ab_tried", {224'd0, tried_count}, 256'd2);
      check_val("ab_nonce", nonce_out, 256'h102);

      // Abort from DONE after a hit clears found
      launch(256'h0, '1, 32'd1);
      tick(); tick();
      check_val("ad_found_pre", {255'd0, found}, 256'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("ad_found", {255'd0, found}, '0);
      check_val("ad_done", {255'd0, done}, '0);

      // start together with abort stays idle
      nonce_base = 256'h300; count_limit = 32'd3; target = '0;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check_val("sa_busy", {255'd0, busy}, '0);
      check_val("sa_done", {255'd0, done}, '0);

      // HASH_LATENCY = 3: evaluations at E4, E8, E12
      rst = 1'b1; tick(); rst = 1'b0;
      launch(256'h20, '0, 32'd3);
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (e == 3)  check_val("l3_tried_e3", {224'd0, tried_count3}, '0);
         if (e == 4)  check_val("l3_tried_e4", {224'd0, tried_count3}, 256'd1);
         if (e == 7)  check_val("l3_tried_e7", {224'd0, tried_count3}, 256'd1);
         if (e == 8)  check_val("l3_tried_e8", {224'd0, tried_count3}, 256'd2);
         if (e == 11) check_val("l3_done_e11", {255'd0, done3}, '0);
      end
      check_val("l3_done", {255'd0, done3}, 256'd1);
      check_val("l3_tried", {224'd0, tried_count3}, 256'd3);
      check_val("l3_nonce", nonce_out3, 256'h22);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
